// File: rtl/station_scheduler_if.sv
// Request/grant bundle between the reservation stations, the LSU status lines
// and the station scheduler.
interface station_scheduler_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IdxW = $clog2(N);

    logic [N-1:0]      st_ready;
    logic [3*N-1:0]    st_a_adr;
    logic [3*N-1:0]    st_b_adr;
    logic [4*N-1:0]    st_d_adr;
    logic [N-1:0]      st_ld_mem;
    logic [N-1:0]      st_st_mem;
    logic [N-1:0]      st_lock_loads;
    logic              lsu_busy;
    logic              lsu_wb;
    logic [N-1:0]      st_ack;
    logic              issue_valid;
    logic [IdxW-1:0]   issue_sel;
    logic [1:0]        ld_outstanding;

    modport master (
        output st_ready, st_a_adr, st_b_adr, st_d_adr, st_ld_mem, st_st_mem, st_lock_loads,
        output lsu_busy, lsu_wb,
        input  st_ack, issue_valid, issue_sel, ld_outstanding
    );

    modport slave (
        input  st_ready, st_a_adr, st_b_adr, st_d_adr, st_ld_mem, st_st_mem, st_lock_loads,
        input  lsu_busy, lsu_wb,
        output st_ack, issue_valid, issue_sel, ld_outstanding
    );
endinterface

// File: rtl/station_scheduler.sv
// Round-robin issue scheduler for reservation stations with register write-pending
// hazard tracking, load-outstanding limit and load-ordering locks.
module station_scheduler #(
    parameter int unsigned N      = 4,
    parameter int unsigned LD_MAX = 2,
    parameter int unsigned WB_LAT = 2
) (
    input logic                clk,
    input logic                a_rst,
    station_scheduler_if.slave bus
);
    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0]         rr_q, rr_d;
    logic [WB_LAT-1:0]       wp_vld_q;
    logic [WB_LAT-1:0][2:0]  wp_reg_q;
    logic [1:0]              ld_q, ld_d;
    logic                    issue_valid_q;
    logic [IdxW-1:0]         issue_sel_q;

    logic [N-1:0]            hazard;
    logic [N-1:0]            eligible;
    logic                    grant;
    logic [IdxW-1:0]         grant_idx;
    logic                    grant_ld;
    logic [3:0]              grant_dst;
    logic                    ld_full;

    assign ld_full = (ld_q >= 2'(LD_MAX));

    always_comb begin : hazard_chk
        hazard = '0;
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < WB_LAT; s++) begin
                if (wp_vld_q[s]) begin
                    if (bus.st_a_adr[3*i +: 3] == wp_reg_q[s] ||
                        bus.st_b_adr[3*i +: 3] == wp_reg_q[s] ||
                        (bus.st_d_adr[4*i + 3] && bus.st_d_adr[4*i +: 3] == wp_reg_q[s])) begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Walk stations from oldest (rr) to youngest; lock_seen blocks younger loads.
    always_comb begin : pick
        logic            lock_seen;
        logic [IdxW-1:0] idx;
        logic            is_ld;
        logic            is_mem;
        eligible  = '0;
        grant     = 1'b0;
        grant_idx = '0;
        lock_seen = 1'b0;
        idx       = '0;
        is_ld     = 1'b0;
        is_mem    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx           = rr_q + IdxW'(k);
            is_ld         = bus.st_ld_mem[idx];
            is_mem        = bus.st_ld_mem[idx] | bus.st_st_mem[idx];
            eligible[idx] = bus.st_ready[idx] & ~hazard[idx] & ~(is_ld & ld_full) &
                            ~(is_mem & bus.lsu_busy) & ~(is_ld & lock_seen);
            if (eligible[idx] && !grant) begin
                grant     = 1'b1;
                grant_idx = idx;
            end
            lock_seen = lock_seen | (bus.st_ready[idx] & bus.st_lock_loads[idx]);
        end
        if (a_rst) begin
            grant = 1'b0;
        end
    end

    always_comb begin : next_state
        grant_ld  = grant & bus.st_ld_mem[grant_idx];
        grant_dst = bus.st_d_adr[4*grant_idx +: 4];
        rr_d      = grant ? grant_idx + IdxW'(1) : rr_q;
        ld_d      = ld_q;
        if (grant_ld && !bus.lsu_wb) begin
            ld_d = ld_q + 2'd1;
        end else if (!grant_ld && bus.lsu_wb && ld_q != 2'd0) begin
            ld_d = ld_q - 2'd1;
        end
    end

    always_comb begin : ack_out
        bus.st_ack = '0;
        if (grant) begin
            bus.st_ack[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            rr_q          <= '0;
            wp_vld_q      <= '0;
            wp_reg_q      <= '0;
            ld_q          <= '0;
            issue_valid_q <= 1'b0;
            issue_sel_q   <= '0;
        end else begin
            rr_q          <= rr_d;
            ld_q          <= ld_d;
            issue_valid_q <= grant;
            if (grant) begin
                issue_sel_q <= grant_idx;
            end
            wp_vld_q[0] <= grant & grant_dst[3];
            wp_reg_q[0] <= grant_dst[2:0];
            for (int s = 1; s < WB_LAT; s++) begin
                wp_vld_q[s] <= wp_vld_q[s-1];
                wp_reg_q[s] <= wp_reg_q[s-1];
            end
        end
    end

    assign bus.issue_valid    = issue_valid_q;
    assign bus.issue_sel      = issue_sel_q;
    assign bus.ld_outstanding = ld_q;
endmodule

// File: tb/tb_station_scheduler.sv
// Bench for station_scheduler: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the issue rules.
module tb_station_scheduler;
    localparam int N      = 4;
    localparam int LD_MAX = 2;
    localparam int WB_LAT = 2;

    logic clk = 1'b0;
    logic a_rst;
    always #5 clk = ~clk;

    station_scheduler_if #(.N(N)) bus ();

    station_scheduler #(.N(N), .LD_MAX(LD_MAX), .WB_LAT(WB_LAT)) dut (
        .clk  (clk),
        .a_rst(a_rst),
        .bus  (bus)
    );

    typedef struct {int r; int c;} wr_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  m_rr, m_ld, m_cyc, m_is;
    bit  m_iv;
    wr_t m_wr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_rr = 0; m_ld = 0; m_iv = 0; m_is = 0;
        m_wr.delete();
    endfunction

    // A register is unreadable for WB_LAT cycles after the cycle its writer issued.
    function automatic bit pending(input int r);
        foreach (m_wr[j]) begin
            if (m_wr[j].r == r && m_cyc - m_wr[j].c >= 1 && m_cyc - m_wr[j].c <= WB_LAT) return 1;
        end
        return 0;
    endfunction

    function automatic int model_grant();
        bit lock_seen = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            bit ld, mem, haz;
            i   = (m_rr + k) % N;
            ld  = bus.st_ld_mem[i];
            mem = bus.st_ld_mem[i] | bus.st_st_mem[i];
            haz = pending(int'(bus.st_a_adr[3*i +: 3])) || pending(int'(bus.st_b_adr[3*i +: 3])) ||
                  (bus.st_d_adr[4*i + 3] && pending(int'(bus.st_d_adr[4*i +: 3])));
            if (bus.st_ready[i] && !haz && !(ld && m_ld == LD_MAX) && !(mem && bus.lsu_busy) &&
                !(ld && lock_seen)) return i;
            if (bus.st_ready[i] && bus.st_lock_loads[i]) lock_seen = 1;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.st_ready = '0; bus.st_a_adr = '0; bus.st_b_adr = '0; bus.st_d_adr = '0;
        bus.st_ld_mem = '0; bus.st_st_mem = '0; bus.st_lock_loads = '0;
        bus.lsu_busy = 1'b0; bus.lsu_wb = 1'b0;
    endtask

    task automatic set_st(input int i, input bit rdy, input int a, input int d,
                          input bit ld, input bit st, input bit lk);
        bus.st_ready[i]      = rdy;
        bus.st_a_adr[3*i +: 3] = 3'(a);
        bus.st_b_adr[3*i +: 3] = 3'd0;
        bus.st_d_adr[4*i +: 4] = 4'(d);
        bus.st_ld_mem[i]     = ld;
        bus.st_st_mem[i]     = st;
        bus.st_lock_loads[i] = lk;
    endtask

    // Inputs are set at the falling edge; check mid-cycle, then advance the model.
    // want >= 0 / -1 additionally pins the DUT grant to a known station / none.
    task automatic step(input string tag, input int want);
        int g;
        logic [N-1:0] exp_ack;
        logic [3:0] dst;
        bit ld_g, wb;
        #1;
        g       = model_grant();
        exp_ack = (g >= 0) ? (N'(1) << g) : '0;
        check({tag, " ack"}, 32'(bus.st_ack), 32'(exp_ack));
        check({tag, " issue_valid"}, 32'(bus.issue_valid), 32'(m_iv));
        check({tag, " issue_sel"}, 32'(bus.issue_sel), 32'(m_is));
        check({tag, " ld_outstanding"}, 32'(bus.ld_outstanding), 32'(m_ld));
        if (want != -2) begin
            check({tag, " directed ack"}, 32'(bus.st_ack), (want >= 0) ? (32'd1 << want) : 32'd0);
        end
        dst  = (g >= 0) ? bus.st_d_adr[4*g +: 4] : 4'd0;
        ld_g = (g >= 0) && bus.st_ld_mem[g];
        wb   = bus.lsu_wb;
        @(posedge clk);
        if (g >= 0) begin
            if (dst[3]) m_wr.push_back('{r: int'(dst[2:0]), c: m_cyc});
            m_rr = (g + 1) % N;
            m_is = g;
        end
        if (ld_g && !wb) m_ld++;
        else if (!ld_g && wb && m_ld > 0) m_ld--;
        m_iv = (g >= 0);
        m_cyc++;
        while (m_wr.size() > 0 && m_cyc - m_wr[0].c > WB_LAT) void'(m_wr.pop_front());
        @(negedge clk);
    endtask

    task automatic random_inputs();
        for (int i = 0; i < N; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            bus.st_ready[i]        = ($urandom_range(0, 99) < 60);
            bus.st_a_adr[3*i +: 3] = 3'($urandom_range(0, 7));
            bus.st_b_adr[3*i +: 3] = 3'($urandom_range(0, 7));
            bus.st_d_adr[4*i +: 4] = 4'($urandom_range(0, 15));
            bus.st_ld_mem[i]       = (kind == 2);
            bus.st_st_mem[i]       = (kind == 3);
            bus.st_lock_loads[i]   = ($urandom_range(0, 99) < 15);
        end
        bus.lsu_busy = ($urandom_range(0, 99) < 25);
        bus.lsu_wb   = ($urandom_range(0, 99) < 30);
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        clear_inputs();
        a_rst = 1'b1;
        bus.st_ready = '1;
        repeat (2) @(negedge clk);
        #1;
        check("reset ack", 32'(bus.st_ack), 32'd0);
        check("reset issue_valid", 32'(bus.issue_valid), 32'd0);
        check("reset issue_sel", 32'(bus.issue_sel), 32'd0);
        check("reset ld_outstanding", 32'(bus.ld_outstanding), 32'd0);
        @(negedge clk);
        a_rst = 1'b0;

        // Round robin over four always-ready ALU stations.
        for (int i = 0; i < N; i++) set_st(i, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) step("rr", i);
        clear_inputs();
        step("rr tail", -1);

        // RAW hazard on r3 holds the consumer for WB_LAT cycles.
        set_st(0, 1, 0, 4'hB, 0, 0, 0);
        step("raw producer", 0);
        clear_inputs();
        set_st(1, 1, 3, 0, 0, 0, 0);
        step("raw hold1", -1);
        step("raw hold2", -1);
        step("raw release", 1);
        clear_inputs();

        // Load limit (rr = 2 here).
        set_st(2, 1, 0, 0, 1, 0, 0);
        step("ld first", 2);
        clear_inputs();
        set_st(3, 1, 0, 0, 1, 0, 0);
        step("ld second", 3);
        clear_inputs();
        set_st(0, 1, 0, 0, 1, 0, 0);
        step("ld full", -1);
        bus.lsu_wb = 1'b1;
        step("ld wb", -1);
        bus.lsu_wb = 1'b0;
        step("ld refill", 0);
        clear_inputs();
        check("ld back at max", 32'(bus.ld_outstanding), 32'd2);

        // Grant and return in the same cycle.
        bus.lsu_wb = 1'b1;
        step("drain", -1);
        set_st(1, 1, 0, 0, 1, 0, 0);
        step("ld with wb", 1);
        clear_inputs();
        check("ld grant+wb", 32'(bus.ld_outstanding), 32'd1);

        // Lock: bring rr to 0, then an older locking store blocks a younger load.
        set_st(2, 1, 0, 0, 0, 0, 0);
        step("lock pre2", 2);
        clear_inputs();
        set_st(3, 1, 0, 0, 0, 0, 0);
        step("lock pre3", 3);
        clear_inputs();
        set_st(0, 1, 0, 0, 0, 1, 1);
        set_st(1, 1, 0, 0, 1, 0, 0);
        bus.lsu_busy = 1'b1;
        step("lock busy", -1);
        bus.lsu_busy = 1'b0;
        step("lock store", 0);
        set_st(0, 0, 0, 0, 0, 0, 0);
        step("lock load", 1);
        clear_inputs();

        for (int c = 0; c < 600; c++) begin
            random_inputs();
            step("rnd", -2);
        end

        // Asynchronous reset during active issue with loads outstanding.
        clear_inputs();
        for (int i = 0; i < N; i++) set_st(i, 1, 0, 0, 1, 0, 0);
        step("pre reset a", -2);
        step("pre reset b", -2);
        #2 a_rst = 1'b1;
        #1;
        check("async ack", 32'(bus.st_ack), 32'd0);
        check("async issue_valid", 32'(bus.issue_valid), 32'd0);
        check("async ld_outstanding", 32'(bus.ld_outstanding), 32'd0);
        @(negedge clk);
        a_rst = 1'b0;
        model_reset();
        clear_inputs();
        bus.lsu_wb = 1'b1;
        step("wb after reset", -1);
        clear_inputs();
        for (int i = 0; i < N; i++) set_st(i, 1, 0, 0, 0, 0, 0);
        step("rr after reset", 0);
        clear_inputs();
        step("post reset tail", -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/station_scheduler.md
STATION_SCHEDULER -- requirements
Module: station_scheduler

Interface
REQ-001 SHALL have parameter N, default 4, the number of reservation stations served; only N=4 is required.
REQ-002 SHALL have parameter LD_MAX, default 2, the maximum number of loads outstanding at the LSU.
REQ-003 SHALL have parameter WB_LAT, default 2, the number of cycles an issued register write remains unreadable.
REQ-004 SHALL have the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- a_rst  in  1  asynchronous reset, active-high.
- st_ready  in  N  station i holds a uOp ready to issue.
- st_a_adr  in  3N  A operand address of station i, packed at [3i+2:3i].
- st_b_adr  in  3N  B operand address of station i.
- st_d_adr  in  4N  destination of station i; bit 3 = write enable, bits [2:0] = register.
- st_ld_mem  in  N  uOp of station i is a load.
- st_st_mem  in  N  uOp of station i is a store.
- st_lock_loads  in  N  station i blocks younger loads.
- lsu_busy  in  1  LSU cannot accept a memory uOp this cycle.
- lsu_wb  in  1  one load data return (write-back) this cycle.
- st_ack  out  N  one-hot grant to station i; combinational.
- issue_valid  out  1  registered: a uOp was granted last cycle.
- issue_sel  out  2  registered: index of the station granted last cycle.
- ld_outstanding  out  2  current count of outstanding loads.

Function
REQ-005 SHALL keep a round-robin pointer rr (2 bits); priority order is rr, rr+1, ... mod N; station rr is the oldest.
REQ-006 SHALL treat a station as eligible when it is ready and none of the following holds:
- a hazard (REQ-007);
- it is a load and ld_outstanding == LD_MAX;
- it is a load or a store and lsu_busy = 1;
- it is a load and an older ready station has st_lock_loads = 1.
REQ-007 SHALL flag a hazard when st_a_adr or st_b_adr equals the register of any valid entry in the write-pending pipe, or when st_d_adr[3]=1 and st_d_adr[2:0] equals such a register.
REQ-008 SHALL assert at most one st_ack bit per cycle: the first eligible station in priority order.
REQ-009 SHALL leave st_ack all-zero when no station is eligible.
REQ-010 SHALL, on a grant to station g, set rr to (g+1) mod N at the next edge; without a grant, rr SHALL hold.
REQ-011 SHALL implement the write-pending pipe as WB_LAT stages of {valid, reg[2:0]}.
- Stage 0 loads {st_d_adr[3] of the granted station, its register}; with no grant it loads valid = 0.
- Each stage shifts to the next every cycle; the last stage drops out.
REQ-012 SHALL update ld_outstanding as follows:
- +1 on a load grant; -1 on lsu_wb; unchanged when both occur in the same cycle.
- lsu_wb at 0 SHALL leave the count at 0 (saturate).
- A load grant at LD_MAX is impossible by REQ-006.
REQ-013 SHALL register issue_valid and issue_sel from the grant with 1-cycle latency; issue_sel SHALL hold its value when issue_valid = 0.
REQ-014 SHALL treat st_ack as valid only while st_ready is high; a station dropping st_ready in the same cycle is not granted.
REQ-015 SHALL decide grants only from current-cycle inputs and registered state, with no combinational path from st_ack back into eligibility.

Reset
REQ-016 SHALL, while a_rst = 1, drive rr = 0, all pipe stages valid = 0, ld_outstanding = 0, issue_valid = 0 and issue_sel = 0.
REQ-017 SHALL drive st_ack = 0 while a_rst = 1, regardless of st_ready.
REQ-018 SHALL discard any grant in flight when reset is asserted mid-operation; lsu_wb arriving after reset SHALL NOT make the count negative (REQ-012).

Verification
REQ-019 Round robin: st_ready=1111, no hazards, 4 cycles -> st_ack = 0001, 0010, 0100, 1000; issue_sel = 0,1,2,3 one cycle later.
REQ-020 RAW hazard: station 0 granted with d=4'b1011; next cycle station 1 ready with a_adr=3 -> station 1 held 2 cycles (WB_LAT), granted in the 3rd.
REQ-021 Load limit: two loads granted, no lsu_wb -> a third ready load gets no ack; lsu_wb pulse -> load granted the next cycle, ld_outstanding stays 2.
REQ-022 Simultaneous grant and return: load granted with lsu_wb=1 and ld_outstanding=1 -> count stays 1.
REQ-023 Lock: rr=0, station 0 a ready store with lock_loads=1 and lsu_busy=1, station 1 a ready load -> no ack; lsu_busy=0 -> station 0 acked first, station 1 acked the next cycle.
REQ-024 Reset mid-run: a_rst pulse during issue -> st_ack=0, issue_valid=0, ld_outstanding=0, rr=0 immediately (asynchronously), not at the next clock edge.
